// File: rtl/esd_multi_controller.sv
`default_nettype none
// ============================================================================
// Module   : esd_multi_controller
// Purpose  : Multi-channel emergency-stop supervisor with debounced inputs,
//            host watchdog, channel discrepancy lockout and status LED.
// Revision : 1.0 - initial release
// ============================================================================
module esd_multi_controller #(
    parameter int N_CH      = 2,
    parameter int DEB_CYC   = 4,
    parameter int WDG_TO    = 1000,
    parameter int DISC_CYC  = 16,
    parameter int BLINK_DIV = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] estop_n,
    input  logic            ack_n,
    input  logic            wdg_kick,
    output logic            shutdown_o,
    output logic            led_stat_o,
    output logic [1:0]      fault_code_o,
    output logic [N_CH-1:0] trip_mask_o
);

    localparam int c_NS      = N_CH + 2;
    localparam int c_DEB_W   = (DEB_CYC > 1)   ? $clog2(DEB_CYC)   : 1;
    localparam int c_ARM_W   = $clog2(DEB_CYC + 3);
    localparam int c_WDG_W   = (WDG_TO > 1)    ? $clog2(WDG_TO)    : 1;
    localparam int c_DISC_W  = (DISC_CYC > 1)  ? $clog2(DISC_CYC)  : 1;
    localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_NS-1:0]      c_SYNC_INIT = {1'b0, 1'b1, {N_CH{1'b1}}};
    localparam logic [c_DEB_W-1:0]   c_DEB_MAX   = c_DEB_W'(DEB_CYC - 1);
    localparam logic [c_ARM_W-1:0]   c_ARM_MAX   = c_ARM_W'(DEB_CYC + 2);
    localparam logic [c_WDG_W-1:0]   c_WDG_MAX   = c_WDG_W'(WDG_TO - 1);
    localparam logic [c_DISC_W-1:0]  c_DISC_MAX  = c_DISC_W'(DISC_CYC - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_MAX = c_BLINK_W'(BLINK_DIV - 1);

    localparam logic [1:0] c_ST_SAFE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_TRIP = 2'd2;
    localparam logic [1:0] c_ST_LOCK = 2'd3;

    localparam logic [1:0] c_FC_NONE  = 2'd0;
    localparam logic [1:0] c_FC_ESTOP = 2'd1;
    localparam logic [1:0] c_FC_WDG   = 2'd2;
    localparam logic [1:0] c_FC_LOCK  = 2'd3;

    logic [c_NS-1:0]      r_sync1;
    logic [c_NS-1:0]      r_sync2;
    logic                 r_kick_prev;
    logic [N_CH:0]        w_deb;
    logic [N_CH-1:0]      w_estop_deb;
    logic                 w_ack_deb;
    logic                 r_ack_prev;
    logic [c_ARM_W-1:0]   r_arm_cnt;
    logic                 r_armed;
    logic                 w_kick;
    logic                 w_ack_fall;
    logic                 w_all_high;
    logic                 w_disagree;
    logic                 w_disc_lock;
    logic [c_DISC_W-1:0]  r_disc_cnt;
    logic [c_WDG_W-1:0]   r_wdg_cnt;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic [1:0]           r_state;
    logic [1:0]           w_state_nx;
    logic [1:0]           w_fault_nx;
    logic [N_CH-1:0]      w_mask_nx;
    logic                 w_led_nx;

    // Bit layout of the synchroniser: {kick, ack_n, estop_n[N_CH-1:0]}
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= c_SYNC_INIT;
            r_sync2     <= c_SYNC_INIT;
            r_kick_prev <= 1'b0;
        end else begin
            r_sync1     <= {wdg_kick, ack_n, estop_n};
            r_sync2     <= r_sync1;
            r_kick_prev <= r_sync2[c_NS-1];
        end
    end

    assign w_kick = r_sync2[c_NS-1] & ~r_kick_prev;

    for (genvar gi = 0; gi <= N_CH; gi++) begin : g_deb
        logic               r_val;
        logic [c_DEB_W-1:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_val <= 1'b1;
                r_cnt <= '0;
            end else if (r_sync2[gi] == r_val) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DEB_MAX) begin
                r_val <= r_sync2[gi];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_DEB_W'(1);
            end
        end
        assign w_deb[gi] = r_val;
    end

    assign w_estop_deb = w_deb[N_CH-1:0];
    assign w_ack_deb   = w_deb[N_CH];
    assign w_all_high  = &w_estop_deb;

    // An ack held low through reset must be seen released before a press counts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_prev <= 1'b1;
            r_arm_cnt  <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_ack_prev <= w_ack_deb;
            if (!r_sync2[N_CH])
                r_arm_cnt <= '0;
            else if (r_arm_cnt != c_ARM_MAX)
                r_arm_cnt <= r_arm_cnt + c_ARM_W'(1);
            if (r_arm_cnt == c_ARM_MAX)
                r_armed <= 1'b1;
        end
    end

    assign w_ack_fall = r_armed & r_ack_prev & ~w_ack_deb;

    if (N_CH >= 2) begin : g_disc
        assign w_disagree = ~(&w_estop_deb) & (|w_estop_deb);
    end else begin : g_nodisc
        assign w_disagree = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || !w_disagree)
            r_disc_cnt <= '0;
        else if (r_disc_cnt != c_DISC_MAX)
            r_disc_cnt <= r_disc_cnt + c_DISC_W'(1);
    end

    assign w_disc_lock = w_disagree && (r_disc_cnt == c_DISC_MAX);

    always_comb begin
        w_state_nx = r_state;
        w_fault_nx = fault_code_o;
        w_mask_nx  = trip_mask_o;
        case (r_state)
            c_ST_SAFE: begin
                if (w_ack_fall && w_all_high)
                    w_state_nx = c_ST_RUN;
            end
            c_ST_RUN: begin
                // Estop outranks a simultaneous watchdog expiry
                if (!w_all_high) begin
                    w_state_nx = c_ST_TRIP;
                    w_fault_nx = c_FC_ESTOP;
                    w_mask_nx  = ~w_estop_deb;
                end else if ((r_wdg_cnt == c_WDG_MAX) && !w_kick) begin
                    w_state_nx = c_ST_TRIP;
                    w_fault_nx = c_FC_WDG;
                    w_mask_nx  = '0;
                end
            end
            c_ST_TRIP: begin
                if (w_ack_fall && w_all_high) begin
                    w_state_nx = c_ST_RUN;
                    w_fault_nx = c_FC_NONE;
                    w_mask_nx  = '0;
                end
            end
            c_ST_LOCK: begin
                w_state_nx = c_ST_LOCK;
            end
            default: begin
                w_state_nx = c_ST_SAFE;
                w_fault_nx = c_FC_NONE;
                w_mask_nx  = '0;
            end
        endcase
        if (w_disc_lock && (r_state != c_ST_LOCK)) begin
            w_state_nx = c_ST_LOCK;
            w_fault_nx = c_FC_LOCK;
            w_mask_nx  = ~w_estop_deb;
        end
    end

    always_comb begin
        w_led_nx = 1'b0;
        case (w_state_nx)
            c_ST_RUN, c_ST_LOCK: w_led_nx = 1'b1;
            c_ST_TRIP: begin
                if (r_state != c_ST_TRIP)
                    w_led_nx = 1'b1;
                else if (r_blink_cnt == c_BLINK_MAX)
                    w_led_nx = ~led_stat_o;
                else
                    w_led_nx = led_stat_o;
            end
            default: w_led_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_SAFE;
            shutdown_o   <= 1'b1;
            led_stat_o   <= 1'b0;
            fault_code_o <= c_FC_NONE;
            trip_mask_o  <= '0;
            r_wdg_cnt    <= '0;
            r_blink_cnt  <= '0;
        end else begin
            r_state      <= w_state_nx;
            shutdown_o   <= (w_state_nx != c_ST_RUN);
            led_stat_o   <= w_led_nx;
            fault_code_o <= w_fault_nx;
            trip_mask_o  <= w_mask_nx;

            // Counter is only live while staying in RUN; entering RUN reloads it
            if ((r_state == c_ST_RUN) && (w_state_nx == c_ST_RUN)) begin
                if (w_kick)
                    r_wdg_cnt <= '0;
                else if (r_wdg_cnt != c_WDG_MAX)
                    r_wdg_cnt <= r_wdg_cnt + c_WDG_W'(1);
            end else begin
                r_wdg_cnt <= '0;
            end

            if ((r_state == c_ST_TRIP) && (w_state_nx == c_ST_TRIP)) begin
                if (r_blink_cnt == c_BLINK_MAX)
                    r_blink_cnt <= '0;
                else
                    r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
            end else begin
                r_blink_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire
